// File: rtl/e_muldiv_unit.sv
// Execute-stage multiply/divide unit owning the architectural HI/LO registers.
// Results are computed at issue, held in pending registers, and committed after a fixed busy window.
module e_muldiv_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_start,
   input  logic [3:0]  i_op,
   input  logic [31:0] i_rs_data,
   input  logic [31:0] i_rt_data,
   output logic        o_busy,
   output logic [31:0] o_hilo_out,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;

   localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      r_state, w_state_nxt;
   logic [3:0]  r_cnt, w_cnt_nxt;
   logic [31:0] r_hi, w_hi_nxt;
   logic [31:0] r_lo, w_lo_nxt;
   logic [31:0] r_pend_hi, w_pend_hi_nxt;
   logic [31:0] r_pend_lo, w_pend_lo_nxt;
   logic        r_commit, w_commit_nxt;

   logic signed [63:0] w_prod_s;
   logic [63:0]        w_prod_u;
   logic               w_div_signed;
   logic               w_rs_neg;
   logic               w_rt_neg;
   logic [31:0]        w_div_a;
   logic [31:0]        w_div_b;
   logic [31:0]        w_uquot;
   logic [31:0]        w_urem;
   logic [31:0]        w_quot;
   logic [31:0]        w_rem;

   assign w_prod_s = $signed({{32{i_rs_data[31]}}, i_rs_data}) * $signed({{32{i_rt_data[31]}}, i_rt_data});
   assign w_prod_u = {32'b0, i_rs_data} * {32'b0, i_rt_data};

   // Signed divide runs on magnitudes; 0x80000000 / -1 then wraps naturally to 0x80000000.
   assign w_div_signed = (i_op == OP_DIV);
   assign w_rs_neg     = w_div_signed && i_rs_data[31];
   assign w_rt_neg     = w_div_signed && i_rt_data[31];
   assign w_div_a      = w_rs_neg ? (32'd0 - i_rs_data) : i_rs_data;
   assign w_div_b      = (i_rt_data == 32'd0) ? 32'd1 : (w_rt_neg ? (32'd0 - i_rt_data) : i_rt_data);
   assign w_uquot      = w_div_a / w_div_b;
   assign w_urem       = w_div_a % w_div_b;
   assign w_quot       = (w_rs_neg ^ w_rt_neg) ? (32'd0 - w_uquot) : w_uquot;
   assign w_rem        = w_rs_neg ? (32'd0 - w_urem) : w_urem;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= 4'd0;
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
         r_pend_hi <= 32'd0;
         r_pend_lo <= 32'd0;
         r_commit  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_hi      <= w_hi_nxt;
         r_lo      <= w_lo_nxt;
         r_pend_hi <= w_pend_hi_nxt;
         r_pend_lo <= w_pend_lo_nxt;
         r_commit  <= w_commit_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_hi_nxt      = r_hi;
      w_lo_nxt      = r_lo;
      w_pend_hi_nxt = r_pend_hi;
      w_pend_lo_nxt = r_pend_lo;
      w_commit_nxt  = r_commit;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               case (i_op)
                  OP_MULT, OP_MULTU: begin
                     w_pend_hi_nxt = (i_op == OP_MULT) ? w_prod_s[63:32] : w_prod_u[63:32];
                     w_pend_lo_nxt = (i_op == OP_MULT) ? w_prod_s[31:0]  : w_prod_u[31:0];
                     w_commit_nxt  = 1'b1;
                     w_cnt_nxt     = MULT_CNT;
                     w_state_nxt   = RUN;
                  end
                  OP_DIV, OP_DIVU: begin
                     w_pend_hi_nxt = w_rem;
                     w_pend_lo_nxt = w_quot;
                     w_commit_nxt  = (i_rt_data != 32'd0);
                     w_cnt_nxt     = DIV_CNT;
                     w_state_nxt   = RUN;
                  end
                  OP_MTHI: w_hi_nxt = i_rs_data;
                  OP_MTLO: w_lo_nxt = i_rs_data;
                  default: ;
               endcase
            end
         end
         RUN: begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
               if (r_commit) begin
                  w_hi_nxt = r_pend_hi;
                  w_lo_nxt = r_pend_lo;
               end
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // The hazard unit must never issue while busy; such a start is dropped.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(i_start && o_busy)) else $warning("start while busy ignored");
      end
   end

   assign o_busy     = (r_state == RUN);
   assign o_hi       = r_hi;
   assign o_lo       = r_lo;
   assign o_hilo_out = (i_op == OP_MFHI) ? r_hi : ((i_op == OP_MFLO) ? r_lo : 32'd0);

endmodule

// File: doc/e_muldiv_unit.md
Name: e_muldiv_unit

Overview:
- Execute-stage multiply/divide unit. Owns the architectural HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from the E stage and runs fixed-latency multi-cycle operations.
- Drives hilo_out into the E/M pipeline register's HILO input.
- busy goes to the hazard unit, which stalls D-stage mul/div-class instructions.

Parameters:
- MULT_CYCLES, 5, busy duration for MULT/MULTU. Legal range 1..15.
- DIV_CYCLES, 10, busy duration for DIV/DIVU. Legal range 1..15.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse: op is valid this cycle
- op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9-15 NONE
- rs_data  input  32  forwarded rs operand
- rt_data  input  32  forwarded rt operand
- busy  output  1  multi-cycle operation in flight
- hilo_out  output  32  HI when op==MFHI, LO when op==MFLO, else 0. Combinational; start is not required.
- hi  output  32  current HI register (debug/trace)
- lo  output  32  current LO register (debug/trace)

Behaviour:
- Reset (clk edge with reset=1):
  - hi=0, lo=0, busy=0, cnt=0, pending registers=0.
  - Any in-flight operation is discarded; HI/LO do not receive its result.
  - reset overrides start on the same edge.
- States: IDLE (busy=0) and RUN (busy=1). The counter cnt is 4 bits.
- IDLE, start=1, op MULT/MULTU, at edge T:
  - Latch the full 64-bit product into pend_hi/pend_lo.
  - MULT is signed 32x32; MULTU is unsigned.
  - Set cnt=MULT_CYCLES, busy=1, go to RUN.
- IDLE, start=1, op DIV/DIVU, at edge T:
  - Latch pend_lo=quotient, pend_hi=remainder.
  - DIV is signed: quotient truncates toward zero; remainder takes the dividend's sign.
  - DIVU is unsigned.
  - Set cnt=DIV_CYCLES, busy=1, go to RUN.
- Divide by zero (rt_data==0): busy sequence runs normally; at completion HI/LO are left unchanged (no commit).
- RUN:
  - cnt decrements on each edge.
  - On the edge where cnt goes 1->0: hi<=pend_hi, lo<=pend_lo, busy<=0, go to IDLE.
  - busy is therefore high for exactly N cycles (T+1..T+N). Updated HI/LO are visible from cycle T+N+1.
- MTHI/MTLO in IDLE: hi<=rs_data (MTHI) or lo<=rs_data (MTLO) at the same edge. No busy.
- MFHI/MFLO: hilo_out reads the current register value, including the value committed on the immediately preceding edge. Never stalls internally.
- start=1 while busy=1, any op: ignored. State, cnt, pend and HI/LO are unaffected. The hazard unit guarantees this never happens; it is asserted in simulation.
- MFHI/MFLO while busy=1: hilo_out returns the old (pre-commit) value. This is legal only because the hazard unit stalls the instruction.
- start=1 with op NONE (0 or 9-15): no effect.
- Width rules:
  - Signed products use 64-bit sign-extended operands; unsigned products use zero extension.
  - Signed DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wrapped).
- Back-to-back operations:
  - A new start is accepted on the edge of the same cycle in which busy is already 0, i.e. cycle T+N+1 or later.
  - An MF in the commit cycle+1 sees the new value.

Test Plan:
- Reset, then MULT rs=0xFFFFFFFE (-2), rt=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MFHI gives hilo_out=0xFFFFFFFF.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> busy exactly 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU rs=7, rt=2 -> lo=3, hi=1.
- MTHI 0x12345678, then DIVU by rt=0 -> busy 10 cycles; hi stays 0x12345678 and lo stays at its prior value.
- Start MULT, assert reset in cycle T+3 -> next edge busy=0, hi=lo=0. No commit appears on subsequent edges.
- While busy: start=1 with MTLO 0xAAAA -> lo unchanged and busy count unaltered. MFLO during busy returns the old lo; MFLO in the cycle after busy falls returns the new lo.
